// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage program counter sequencer.
package pc_pkg;

    typedef enum logic [1:0] {
        REDIR_BRANCH = 2'd0,
        REDIR_JALR   = 2'd1,
        REDIR_TRAP   = 2'd2,
        REDIR_RSVD   = 2'd3
    } redir_e;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

    localparam logic [1:0] REDIR_W = 2'd2;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect target computation with alignment check against INC.
module pc_target_calc
    import pc_pkg::*;
#(
    parameter int          PC_WIDTH    = 32,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100,
    parameter int          INC         = 4
) (
    input  logic [1:0]          mode,
    input  logic [PC_WIDTH-1:0] base,
    input  logic [PC_WIDTH-1:0] offset,
    output logic [PC_WIDTH-1:0] target,
    output logic                misaligned_tgt
);

    localparam logic [PC_WIDTH-1:0] INC_W  = PC_WIDTH'(INC);
    localparam logic [PC_WIDTH-1:0] TRAP_W = PC_WIDTH'(TRAP_VECTOR);

    logic [PC_WIDTH-1:0] sum;

    assign sum = base + offset;

    always_comb begin
        target         = TRAP_W;
        misaligned_tgt = 1'b0;
        case (redir_e'(mode))
            REDIR_BRANCH: begin
                target         = sum;
                misaligned_tgt = (sum % INC_W) != '0;
            end
            REDIR_JALR: begin
                target         = {sum[PC_WIDTH-1:1], 1'b0};
                misaligned_tgt = ({sum[PC_WIDTH-1:1], 1'b0} % INC_W) != '0;
            end
            // TRAP and the reserved encoding both vector to the trap handler
            default: begin
                target         = TRAP_W;
                misaligned_tgt = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC: BOOT/RUN/HALT FSM, valid/ready fetch handshake, redirect flush and
// misaligned-target trapping.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int          PC_WIDTH     = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int          INC          = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch_ready,
    input  logic                stall,
    input  logic                halt_req,
    input  logic                resume,
    input  logic                redirect_valid,
    input  logic [1:0]          redirect_mode,
    input  logic [PC_WIDTH-1:0] redirect_base,
    input  logic [PC_WIDTH-1:0] redirect_offset,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus_inc,
    output logic                fetch_valid,
    output logic                misaligned,
    output logic [PC_WIDTH-1:0] trap_epc,
    output logic                halted
);

    localparam logic [PC_WIDTH-1:0] INC_W   = PC_WIDTH'(INC);
    localparam logic [PC_WIDTH-1:0] TRAP_W  = PC_WIDTH'(TRAP_VECTOR);
    localparam logic [PC_WIDTH-1:0] RESET_W = PC_WIDTH'(RESET_VECTOR);

    pc_state_e           state, state_next;
    logic [PC_WIDTH-1:0] target, pc_next;
    logic                misaligned_tgt, advance;

    pc_target_calc #(
        .PC_WIDTH    (PC_WIDTH),
        .TRAP_VECTOR (TRAP_VECTOR),
        .INC         (INC)
    ) u_target (
        .mode           (redirect_mode),
        .base           (redirect_base),
        .offset         (redirect_offset),
        .target         (target),
        .misaligned_tgt (misaligned_tgt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_BOOT;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_BOOT: state_next = ST_RUN;
            ST_RUN:  if (!redirect_valid && halt_req) state_next = ST_HALT;
            ST_HALT: if (redirect_valid || resume) state_next = ST_RUN;
            default: state_next = ST_BOOT;
        endcase
    end

    always_comb begin
        fetch_valid = (state == ST_RUN);
        halted      = (state == ST_HALT);
    end

    // Redirect flushes from any state and overrides stall, backpressure and halt_req.
    assign advance = (state == ST_RUN) && !redirect_valid && !halt_req && !stall && fetch_ready;

    always_comb begin
        pc_next = pc;
        if (redirect_valid) pc_next = misaligned_tgt ? TRAP_W : target;
        else if (advance)   pc_next = pc + INC_W;
    end

    assign pc_plus_inc = pc + INC_W;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_W;
            misaligned <= 1'b0;
            trap_epc   <= '0;
        end else begin
            pc         <= pc_next;
            misaligned <= redirect_valid && misaligned_tgt;
            if (redirect_valid && misaligned_tgt) trap_epc <= target;
        end
    end

endmodule
